// File: rtl/ball_mapper_multi.sv
// Three-stage colour mapper: draws up to N_BALLS circles/squares over a gradient
// background, with a run-time writable per-ball palette.
module ball_mapper_multi #(
   parameter int unsigned  N_BALLS     = 4,
   parameter int unsigned  COORD_W     = 10,
   parameter logic [7:0]   BG_RED_BASE = 8'h4F,
   parameter logic [7:0]   BG_BLUE     = 8'h44,
   parameter logic [23:0]  RESET_COLOR = 24'h00FFFF,
   localparam int unsigned IDX_W       = (N_BALLS > 1) ? $clog2(N_BALLS) : 1
) (
   input  logic                         Clk,
   input  logic                         Reset,
   input  logic                         Pix_valid,
   input  logic [COORD_W-1:0]           DrawX,
   input  logic [COORD_W-1:0]           DrawY,
   input  logic [N_BALLS*COORD_W-1:0]   BallX,
   input  logic [N_BALLS*COORD_W-1:0]   BallY,
   input  logic [N_BALLS*COORD_W-1:0]   Ball_size,
   input  logic [N_BALLS-1:0]           Ball_en,
   input  logic                         Shape_sq,
   input  logic                         Pal_we,
   input  logic [IDX_W-1:0]             Pal_idx,
   input  logic [23:0]                  Pal_data,
   output logic [7:0]                   Red,
   output logic [7:0]                   Green,
   output logic [7:0]                   Blue,
   output logic                         RGB_valid,
   output logic [IDX_W-1:0]             Hit_idx,
   output logic                         Hit
);

   localparam int unsigned DW  = COORD_W + 1;
   localparam int unsigned PW  = 2 * COORD_W + 2;
   localparam int unsigned SQW = 2 * COORD_W + 3;
   localparam int unsigned SZW = 2 * COORD_W;
   localparam int unsigned XCW = COORD_W - 3;

   // stage 1: signed distances and sampled ball parameters
   logic signed [DW-1:0]  dx1_d [N_BALLS], dx1_q [N_BALLS];
   logic signed [DW-1:0]  dy1_d [N_BALLS], dy1_q [N_BALLS];
   logic [COORD_W-1:0]    sz1_d [N_BALLS], sz1_q [N_BALLS];
   logic [N_BALLS-1:0]    en1_d, en1_q;
   logic                  sq1_d, sq1_q;
   logic [XCW-1:0]        xc1_d, xc1_q;
   logic                  v1_d, v1_q;

   // stage 2: squared distances / absolute distances
   logic [SQW-1:0]        dsq2_d [N_BALLS], dsq2_q [N_BALLS];
   logic [SZW-1:0]        szsq2_d [N_BALLS], szsq2_q [N_BALLS];
   logic [COORD_W-1:0]    ax2_d [N_BALLS], ax2_q [N_BALLS];
   logic [COORD_W-1:0]    ay2_d [N_BALLS], ay2_q [N_BALLS];
   logic [COORD_W-1:0]    sz2_d [N_BALLS], sz2_q [N_BALLS];
   logic [N_BALLS-1:0]    en2_d, en2_q;
   logic                  sq2_d, sq2_q;
   logic [XCW-1:0]        xc2_d, xc2_q;
   logic                  v2_d, v2_q;

   // stage 3 outputs and palette
   logic [7:0]            red_d, red_q, green_d, green_q, blue_d, blue_q;
   logic                  hit_d, hit_q, vld_d, vld_q;
   logic [IDX_W-1:0]      idx_d, idx_q;
   logic [23:0]           pal_d [N_BALLS], pal_q [N_BALLS];

   logic [N_BALLS-1:0]    hit_vec;
   logic [IDX_W-1:0]      win;
   logic signed [PW-1:0]  px, py;
   logic                  unused_drawx_lsb;

   assign unused_drawx_lsb = ^DrawX[2:0];

   always_comb begin
      en1_d = Ball_en;
      sq1_d = Shape_sq;
      xc1_d = DrawX[COORD_W-1:3];
      v1_d  = Pix_valid;
      for (int i = 0; i < N_BALLS; i++) begin
         dx1_d[i] = $signed({1'b0, DrawX}) - $signed({1'b0, BallX[i*COORD_W +: COORD_W]});
         dy1_d[i] = $signed({1'b0, DrawY}) - $signed({1'b0, BallY[i*COORD_W +: COORD_W]});
         sz1_d[i] = Ball_size[i*COORD_W +: COORD_W];
      end
   end

   always_comb begin
      px    = '0;
      py    = '0;
      en2_d = en1_q;
      sq2_d = sq1_q;
      xc2_d = xc1_q;
      v2_d  = v1_q;
      for (int i = 0; i < N_BALLS; i++) begin
         px         = PW'(dx1_q[i]) * PW'(dx1_q[i]);
         py         = PW'(dy1_q[i]) * PW'(dy1_q[i]);
         dsq2_d[i]  = SQW'(px) + SQW'(py);
         szsq2_d[i] = SZW'(sz1_q[i]) * SZW'(sz1_q[i]);
         ax2_d[i]   = dx1_q[i][DW-1] ? COORD_W'(-dx1_q[i]) : COORD_W'(dx1_q[i]);
         ay2_d[i]   = dy1_q[i][DW-1] ? COORD_W'(-dy1_q[i]) : COORD_W'(dy1_q[i]);
         sz2_d[i]   = sz1_q[i];
      end
   end

   // hit test, lowest-index priority and colour selection
   always_comb begin
      hit_vec = '0;
      win     = '0;
      for (int i = 0; i < N_BALLS; i++) begin
         if (sq2_q)
            hit_vec[i] = en2_q[i] && (ax2_q[i] <= sz2_q[i]) && (ay2_q[i] <= sz2_q[i]);
         else
            hit_vec[i] = en2_q[i] && (dsq2_q[i] <= SQW'(szsq2_q[i]));
      end
      for (int i = N_BALLS - 1; i >= 0; i--) begin
         if (hit_vec[i]) win = IDX_W'(i);
      end
      vld_d = v2_q;
      if (|hit_vec) begin
         {red_d, green_d, blue_d} = pal_q[win];
         hit_d = 1'b1;
         idx_d = win;
      end else begin
         red_d   = BG_RED_BASE - 8'(xc2_q);
         green_d = 8'h00;
         blue_d  = BG_BLUE;
         hit_d   = 1'b0;
         idx_d   = '0;
      end
   end

   // out-of-range palette indices are dropped
   always_comb begin
      pal_d = pal_q;
      if (Pal_we && (32'(Pal_idx) < N_BALLS)) pal_d[Pal_idx] = Pal_data;
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         for (int i = 0; i < N_BALLS; i++) begin
            dx1_q[i]   <= '0;
            dy1_q[i]   <= '0;
            sz1_q[i]   <= '0;
            dsq2_q[i]  <= '0;
            szsq2_q[i] <= '0;
            ax2_q[i]   <= '0;
            ay2_q[i]   <= '0;
            sz2_q[i]   <= '0;
            pal_q[i]   <= RESET_COLOR;
         end
         en1_q   <= '0;
         sq1_q   <= 1'b0;
         xc1_q   <= '0;
         v1_q    <= 1'b0;
         en2_q   <= '0;
         sq2_q   <= 1'b0;
         xc2_q   <= '0;
         v2_q    <= 1'b0;
         red_q   <= '0;
         green_q <= '0;
         blue_q  <= '0;
         hit_q   <= 1'b0;
         idx_q   <= '0;
         vld_q   <= 1'b0;
      end else begin
         dx1_q   <= dx1_d;
         dy1_q   <= dy1_d;
         sz1_q   <= sz1_d;
         dsq2_q  <= dsq2_d;
         szsq2_q <= szsq2_d;
         ax2_q   <= ax2_d;
         ay2_q   <= ay2_d;
         sz2_q   <= sz2_d;
         pal_q   <= pal_d;
         en1_q   <= en1_d;
         sq1_q   <= sq1_d;
         xc1_q   <= xc1_d;
         v1_q    <= v1_d;
         en2_q   <= en2_d;
         sq2_q   <= sq2_d;
         xc2_q   <= xc2_d;
         v2_q    <= v2_d;
         red_q   <= red_d;
         green_q <= green_d;
         blue_q  <= blue_d;
         hit_q   <= hit_d;
         idx_q   <= idx_d;
         vld_q   <= vld_d;
      end
   end

   assign Red       = red_q;
   assign Green     = green_q;
   assign Blue      = blue_q;
   assign Hit       = hit_q;
   assign Hit_idx   = idx_q;
   assign RGB_valid = vld_q;

endmodule

// File: tb/tb_ball_mapper_multi.sv
// Bench for ball_mapper_multi: directed scenarios plus randomized traffic against
// a geometric reference model with a 3-edge output latency.
module tb_ball_mapper_multi;

   localparam int unsigned N  = 3;
   localparam int unsigned W  = 10;
   localparam int unsigned IW = 2;

   logic              Clk = 1'b0;
   logic              Reset;
   logic              Pix_valid;
   logic [W-1:0]      DrawX, DrawY;
   logic [N*W-1:0]    BallX, BallY, Ball_size;
   logic [N-1:0]      Ball_en;
   logic              Shape_sq;
   logic              Pal_we;
   logic [IW-1:0]     Pal_idx;
   logic [23:0]       Pal_data;
   logic [7:0]        Red, Green, Blue;
   logic              RGB_valid;
   logic [IW-1:0]     Hit_idx;
   logic              Hit;

   ball_mapper_multi #(.N_BALLS(N), .COORD_W(W)) dut (
      .Clk(Clk), .Reset(Reset), .Pix_valid(Pix_valid), .DrawX(DrawX), .DrawY(DrawY),
      .BallX(BallX), .BallY(BallY), .Ball_size(Ball_size), .Ball_en(Ball_en),
      .Shape_sq(Shape_sq), .Pal_we(Pal_we), .Pal_idx(Pal_idx), .Pal_data(Pal_data),
      .Red(Red), .Green(Green), .Blue(Blue), .RGB_valid(RGB_valid),
      .Hit_idx(Hit_idx), .Hit(Hit)
   );

   always #5 Clk = ~Clk;

   typedef struct packed {
      logic       v;
      logic       hit;
      logic [1:0] idx;
      logic [7:0] bgr;
   } geo_t;

   int          bx [N], by [N], bs [N];
   bit          ben [N];
   logic [23:0] pal_m [N];
   geo_t        s1, s2;
   logic        exp_v, exp_hit;
   logic [1:0]  exp_idx;
   logic [23:0] exp_rgb;
   int          n_cmp = 0;
   int          n_err = 0;

   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // what the pixel should look like, straight from the drawing rules
   function automatic geo_t geom();
      geo_t g;
      int dx, dy;
      bit h;
      g.v   = Pix_valid;
      g.hit = 1'b0;
      g.idx = 2'd0;
      g.bgr = 8'(32'h4F - int'(DrawX) / 8);
      for (int i = N - 1; i >= 0; i--) begin
         dx = int'(DrawX) - bx[i];
         dy = int'(DrawY) - by[i];
         if (Shape_sq)
            h = ben[i] && ((dx < 0 ? -dx : dx) <= bs[i]) && ((dy < 0 ? -dy : dy) <= bs[i]);
         else
            h = ben[i] && (dx * dx + dy * dy <= bs[i] * bs[i]);
         if (h) begin
            g.hit = 1'b1;
            g.idx = 2'(i);
         end
      end
      return g;
   endfunction

   task automatic model_reset();
      s1 = '0;
      s2 = '0;
      for (int i = 0; i < N; i++) pal_m[i] = 24'h00FFFF;
   endtask

   task automatic check();
      cmp("rgb_valid", 32'(RGB_valid), 32'(exp_v));
      if (exp_v) begin
         cmp("hit", 32'(Hit), 32'(exp_hit));
         cmp("hit_idx", 32'(Hit_idx), 32'(exp_idx));
         cmp("rgb", 32'({Red, Green, Blue}), 32'(exp_rgb));
      end else begin
         n_cmp++;
         assert (!$isunknown({Red, Green, Blue, Hit, Hit_idx})) else begin
            n_err++;
            $error("FAIL no_x: observed %h expected no X", {Red, Green, Blue, Hit, Hit_idx});
         end
      end
   endtask

   // one clock: drive balls, advance the model, compare outputs
   task automatic tick();
      geo_t g;
      for (int i = 0; i < N; i++) begin
         BallX[i*W +: W]     = W'(bx[i]);
         BallY[i*W +: W]     = W'(by[i]);
         Ball_size[i*W +: W] = W'(bs[i]);
         Ball_en[i]          = ben[i];
      end
      g = geom();
      @(posedge Clk);
      exp_v   = s2.v;
      exp_hit = s2.hit;
      exp_idx = s2.hit ? s2.idx : 2'd0;
      exp_rgb = s2.hit ? pal_m[s2.idx] : {s2.bgr, 8'h00, 8'h44};
      if (Pal_we && int'(Pal_idx) < N) pal_m[Pal_idx] = Pal_data;
      s2 = s1;
      s1 = g;
      #1 check();
   endtask

   task automatic pix(input int x, input int y, input bit v);
      DrawX = W'(x);
      DrawY = W'(y);
      Pix_valid = v;
      tick();
   endtask

   task automatic lit(input string tag, input bit hit, input int idx, input logic [23:0] rgb);
      cmp({tag, "_hit"}, 32'(Hit), 32'(hit));
      cmp({tag, "_idx"}, 32'(Hit_idx), 32'(idx));
      cmp({tag, "_rgb"}, 32'({Red, Green, Blue}), 32'(rgb));
   endtask

   task automatic expect_px(input string tag, input int x, input int y, input bit hit,
                            input int idx, input logic [23:0] rgb);
      pix(x, y, 1'b1);
      pix(0, 0, 1'b0);
      pix(0, 0, 1'b0);
      cmp({tag, "_valid"}, 32'(RGB_valid), 32'd1);
      lit(tag, hit, idx, rgb);
   endtask

   task automatic set_ball(input int i, input int x, input int y, input int s, input bit en);
      bx[i] = x; by[i] = y; bs[i] = s; ben[i] = en;
   endtask

   function automatic int clampc(input int v);
      return (v < 0) ? 0 : ((v > 1023) ? 1023 : v);
   endfunction

   initial begin
      int base;
      Reset = 1'b0; Pix_valid = 1'b0; DrawX = '0; DrawY = '0;
      BallX = '0; BallY = '0; Ball_size = '0; Ball_en = '0;
      Shape_sq = 1'b0; Pal_we = 1'b0; Pal_idx = '0; Pal_data = '0;
      for (int i = 0; i < N; i++) set_ball(i, 0, 0, 0, 1'b0);
      model_reset();
      #1;
      cmp("rst_valid", 32'(RGB_valid), 32'd0);
      lit("rst", 1'b0, 0, 24'h000000);
      repeat (2) @(posedge Clk);
      @(negedge Clk) Reset = 1'b1;

      // circle boundary
      set_ball(0, 320, 240, 4, 1'b1);
      set_ball(1, 100, 100, 3, 1'b0);
      expect_px("circ_edge", 324, 240, 1'b1, 0, 24'h00FFFF);
      expect_px("circ_out", 323, 243, 1'b0, 0, 24'h270044);

      // square mode
      Shape_sq = 1'b1;
      expect_px("sq_corner", 323, 243, 1'b1, 0, 24'h00FFFF);
      expect_px("sq_out", 325, 240, 1'b0, 0, 24'h270044);

      // priority between overlapping balls
      Shape_sq = 1'b0;
      set_ball(0, 100, 100, 5, 1'b1);
      set_ball(1, 102, 100, 5, 1'b1);
      Pal_we = 1'b1; Pal_idx = 2'd1; Pal_data = 24'hFF0000;
      pix(0, 0, 1'b0);
      Pal_we = 1'b0;
      expect_px("prio0", 100, 100, 1'b1, 0, 24'h00FFFF);
      ben[0] = 1'b0;
      expect_px("prio1", 100, 100, 1'b1, 1, 24'hFF0000);

      // screen-edge arithmetic, size 0 and background gradient
      set_ball(0, 2, 2, 4, 1'b1);
      ben[1] = 1'b0;
      expect_px("edge", 0, 0, 1'b1, 0, 24'h00FFFF);
      set_ball(0, 50, 50, 0, 1'b1);
      expect_px("size0_c", 50, 50, 1'b1, 0, 24'h00FFFF);
      expect_px("size0_n", 51, 50, 1'b0, 0, 24'h490044);
      ben[0] = 1'b0;
      expect_px("bg639", 639, 10, 1'b0, 0, 24'h000044);
      expect_px("bg1023", 1023, 10, 1'b0, 0, 24'hD00044);

      // palette write timing while ball0 pixels stream
      set_ball(0, 320, 240, 4, 1'b1);
      repeat (3) pix(320, 240, 1'b1);
      Pal_we = 1'b1; Pal_idx = 2'd0; Pal_data = 24'h123456;
      pix(320, 240, 1'b1);
      Pal_we = 1'b0;
      lit("pal_old", 1'b1, 0, 24'h00FFFF);
      pix(320, 240, 1'b1);
      lit("pal_new", 1'b1, 0, 24'h123456);
      Pal_we = 1'b1; Pal_idx = 2'd3; Pal_data = 24'hABCDEF;
      pix(320, 240, 1'b1);
      Pal_we = 1'b0;
      pix(320, 240, 1'b1);
      lit("pal_oor", 1'b1, 0, 24'h123456);

      // reset with pixels in flight
      repeat (3) pix(320, 240, 1'b1);
      #2 Reset = 1'b0;
      #1;
      model_reset();
      cmp("mid_rst_valid", 32'(RGB_valid), 32'd0);
      lit("mid_rst", 1'b0, 0, 24'h000000);
      @(posedge Clk);
      @(negedge Clk) Reset = 1'b1;
      pix(0, 0, 1'b0);
      pix(0, 0, 1'b0);
      pix(320, 240, 1'b1);
      pix(0, 0, 1'b0);
      cmp("lat_early", 32'(RGB_valid), 32'd0);
      pix(0, 0, 1'b0);
      cmp("lat_first", 32'(RGB_valid), 32'd1);
      lit("pal_reset", 1'b1, 0, 24'h00FFFF);

      // randomized traffic
      base = 0;
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 7) == 0) begin
            case ($urandom_range(0, 2))
               0:       base = $urandom_range(0, 10);
               1:       base = $urandom_range(1013, 1023);
               default: base = $urandom_range(20, 1000);
            endcase
            for (int i = 0; i < N; i++)
               set_ball(i, clampc(base + $urandom_range(0, 40) - 20),
                        clampc(base + $urandom_range(0, 40) - 20),
                        $urandom_range(0, 12), $urandom_range(0, 3) != 0);
            Shape_sq = $urandom_range(0, 1) == 1;
         end
         Pal_we   = $urandom_range(0, 7) == 0;
         Pal_idx  = 2'($urandom_range(0, 3));
         Pal_data = 24'($urandom);
         pix(clampc(base + $urandom_range(0, 48) - 24), clampc(base + $urandom_range(0, 48) - 24),
             $urandom_range(0, 4) != 0);
      end
      Pal_we = 1'b0;
      repeat (3) pix(0, 0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ball_mapper_multi.md
# ball_mapper_multi

Pipelined, parametrised colour mapper for the VGA path. It renders up to N_BALLS independently placed, sized and coloured balls over a horizontal-gradient background. Each ball is drawn as a circle or a square, selected at run time. It sits between the VGA controller (DrawX/DrawY/valid) and the DAC outputs. Per-ball colours live in an internal palette written by the game logic.

## Interface
- N_BALLS, default 4: number of ball channels, 1..8.
- COORD_W, default 10: width of coordinates and sizes.
- BG_RED_BASE, default 8'h4F: gradient red base.
- BG_BLUE, default 8'h44: constant background blue.
- RESET_COLOR, default 24'h00FFFF: palette reset value for every entry, {R,G,B}.

Ports:
- Clk  in  1  pixel clock, all logic rising-edge.
- Reset  in  1  asynchronous, active-low; clears pipeline and palette.
- Pix_valid  in  1  DrawX/DrawY valid this cycle.
- DrawX, DrawY  in  COORD_W each  current pixel, unsigned.
- BallX, BallY  in  N_BALLS*COORD_W each  packed centres; ball i at [i*COORD_W +: COORD_W], unsigned.
- Ball_size  in  N_BALLS*COORD_W  packed radius (circle) / half-side (square), unsigned.
- Ball_en  in  N_BALLS  per-ball enable.
- Shape_sq  in  1  0 = circle, 1 = square; applies to all balls.
- Pal_we  in  1  palette write strobe.
- Pal_idx  in  $clog2(N_BALLS) (min 1)  palette entry.
- Pal_data  in  24  {R,G,B} colour written.
- Red, Green, Blue  out  8 each  registered colour.
- RGB_valid  out  1  Pix_valid delayed to align with RGB.
- Hit_idx  out  $clog2(N_BALLS) (min 1)  index of the winning ball; 0 when no hit.
- Hit  out  1  some enabled ball covers the pixel.

## Operation
- Stage 1 (registered): for each ball i:
  - DistX_i = DrawX − BallX_i and DistY_i = DrawY − BallY_i, computed signed in COORD_W+1 bits.
  - No unsigned wrap. A ball near the screen edge must still render correctly.
  - Also register Size_i, Ball_en, Shape_sq, DrawX[COORD_W-1:3] and Pix_valid.
- Stage 2 (registered):
  - Circle mode: Sq_i = DistX_i² + DistY_i², unsigned, 2*COORD_W+3 bits. SzSq_i = Size_i², 2*COORD_W bits.
  - Square mode: AbsX_i = |DistX_i| and AbsY_i = |DistY_i|.
- Stage 3 (registered outputs):
  - Circle hit_i = en_i && (Sq_i <= SzSq_i). The boundary is inclusive.
  - Square hit_i = en_i && AbsX_i <= Size_i && AbsY_i <= Size_i.
  - Priority: the lowest index with hit_i wins. Output palette[win], Hit=1, Hit_idx=win.
  - No hit: Red = BG_RED_BASE − DrawX[COORD_W-1:3], modulo 256. Green = 0, Blue = BG_BLUE. Hit = 0, Hit_idx = 0.
- Size 0 is legal in both modes: exactly the centre pixel is drawn. Disabled balls never hit, whatever their geometry.
- Palette:
  - N_BALLS × 24-bit registers.
  - A write with Pal_we=1 updates palette[Pal_idx] at the clock edge.
  - Pal_idx >= N_BALLS: write ignored.
  - Stage 3 reads the registered palette. A write on edge k affects outputs produced on edge k+1 onward. Outputs from edge k use the old value.
- Pix_valid=0: the pipeline still advances, and RGB_valid follows the delayed Pix_valid. RGB while RGB_valid=0 is don't-care but must not be X.
- Shape_sq and ball parameters are sampled in stage 1. Changes mid-frame affect pixels entering from that cycle on. There is no frame-level shadowing.

## Timing
- Latency: 3 cycles. Pixel presented before edge k appears on Red/Green/Blue/Hit/Hit_idx/RGB_valid after edge k+2.
- Throughput: one pixel per clock, no stalls.
- Reset asserted, asynchronously:
  - Red/Green/Blue = 0, Hit = 0, Hit_idx = 0, RGB_valid = 0.
  - All pipeline valids = 0.
  - Palette = RESET_COLOR.
- Reset mid-stream: in-flight pixels are discarded.
- After deassertion: the first RGB_valid=1 is 3 edges after the first Pix_valid=1 sampled.
- Multipliers: 3*N_BALLS in circle mode. They are implemented as pipelined registers in stage 2. No combinational path from DrawX to Red.

## Test plan
- **Circle edge** (N_BALLS=2, COORD_W=10, ball0 (320,240) size 4 enabled, palette0 = 00FFFF):
  - Pixel (324,240) → Hit=1, RGB=00/FF/FF, 3 cycles later.
  - Pixel (323,243) → Hit=0 (18>16), RGB = 27/00/44.
- **Square mode, same setup:** pixel (323,243) → Hit=1, RGB=00/FF/FF. Pixel (325,240) → Hit=0.
- **Priority:** ball0 and ball1 both cover (100,100), palette1 = FF0000 → Hit_idx=0, colour 00FFFF. Clear Ball_en[0] → Hit_idx=1, RGB=FF/00/00.
- **Edge and wrap arithmetic:**
  - Ball0 at (2,2) size 4, pixel (0,0) → Hit=1 (no unsigned wrap).
  - Background DrawX=639 → Red=00.
  - Background DrawX=1023 → Red=D0.
- **Palette timing:**
  - Write Pal_idx=0 with 123456 on edge k while ball0 pixels stream → outputs from edge k+1 onward show 12/34/56. Edge k output shows the old colour.
  - Pal_idx=3 with N_BALLS=2 → no change.
- **Reset mid-stream:** assert Reset with 3 pixels in flight → RGB_valid, Hit, RGB = 0 immediately. Palette returns to 00FFFF. After release, first RGB_valid exactly 3 edges after the first sampled Pix_valid.
